// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: 8N1 frame constants, the
// transmit FSM state encoding and the bit-period clamp helper.
package uart_pkg;

    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned FRAME_BITS     = 10;
    localparam int unsigned MIN_BIT_PERIOD = 2;
    localparam int unsigned PERIOD_W       = 32;
    localparam int unsigned BIT_IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Periods shorter than the minimum would leave no room for the counter reload.
    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] period);
        return (period < PERIOD_W'(MIN_BIT_PERIOD)) ? PERIOD_W'(MIN_BIT_PERIOD) : period;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: synchronous, registered storage, show-ahead head output.
// Ports:
//   clk_i, arst_i  clock, asynchronous active-high reset
//   push_i/data_i  write request and byte (ignored while full)
//   pop_i          read request (ignored while empty)
//   head_o         byte at the read pointer, valid whenever !empty_o
//   empty_o/full_o occupancy flags decoded from the pointers
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = DATA_BITS
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for pointers and storage; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, with a small transmit FIFO in front.
// Ports:
//   clk_i, arst_i            clock, asynchronous active-high reset
//   bit_period_i             clock cycles per bit, clamped to >= 2, latched per frame
//   tx_valid_i/tx_data_i     producer handshake and byte
//   tx_ready_o               FIFO not full
//   tx_o                     registered serial line
//   busy_o                   registered; FSM active or FIFO holding bytes
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic [PERIOD_W-1:0] bit_period_i,
    input  logic                tx_valid_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    output logic                tx_ready_o,
    output logic                tx_o,
    output logic                busy_o
);

    uart_state_e                state_q, state_d;
    logic [PERIOD_W-1:0]        cnt_q, cnt_d;
    logic [PERIOD_W-1:0]        period_q, period_d;
    logic [BIT_IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]       shift_q, shift_d;
    logic                       tx_q, tx_d;
    logic                       busy_q, busy_d;

    logic                       fifo_pop;
    logic [DATA_BITS-1:0]       fifo_head;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [PERIOD_W-1:0]        period_clamped;
    logic                       bit_done;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .push_i  (tx_valid_i),
        .data_i  (tx_data_i),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign tx_ready_o     = !fifo_full;
    assign period_clamped = clamp_period(bit_period_i);
    assign bit_done       = (cnt_q == '0);

    // FSM, bit counter and shifter. The line level is derived from the
    // current state, so tx_o trails the state register by one cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = IDLE_LEVEL;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    period_d = period_clamped;
                    cnt_d    = period_clamped - PERIOD_W'(1);
                    state_d  = START;
                end
            end
            START: begin
                tx_d = ~IDLE_LEVEL;
                if (bit_done) begin
                    cnt_d     = period_q - PERIOD_W'(1);
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_done) begin
                    cnt_d   = period_q - PERIOD_W'(1);
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end
            end
            STOP: begin
                tx_d = IDLE_LEVEL;
                if (bit_done) begin
                    // Chain straight into the next frame when a byte is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        period_d = period_clamped;
                        cnt_d    = period_clamped - PERIOD_W'(1);
                        state_d  = START;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Busy is registered alongside tx so both reflect the same cycle of activity.
    always_comb begin
        busy_d = (state_q != IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues the expected byte and bit
// period; a serial-line monitor checks every cycle of each frame it sees.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int FB = int'(FRAME_BITS);
    localparam int DB = int'(DATA_BITS);

    typedef struct {
        logic [7:0] data;
        int         period;
    } exp_t;

    logic        clk_i        = 1'b0;
    logic        arst_i       = 1'b1;
    logic [31:0] bit_period_i = 32'd4;
    logic        tx_valid_i   = 1'b0;
    logic [7:0]  tx_data_i    = 8'h00;
    logic        tx_ready_o;
    logic        tx_o;
    logic        busy_o;

    exp_t exp_q[$];
    int   frame_starts[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    uart_tx #(
        .FIFO_DEPTH (4),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .bit_period_i (bit_period_i),
        .tx_valid_i   (tx_valid_i),
        .tx_data_i    (tx_data_i),
        .tx_ready_o   (tx_ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int last_start();
        return (frame_starts.size() == 0) ? -1 : frame_starts[frame_starts.size() - 1];
    endfunction

    // Offer a byte; returns the edge number on which it was accepted.
    task automatic push(input logic [7:0] d, input int per, output int acc);
        int waited;
        waited     = 0;
        acc        = -1;
        tx_valid_i = 1'b1;
        tx_data_i  = d;
        while (acc < 0) begin
            @(negedge clk_i);
            if (tx_ready_o) begin
                acc = cyc + 1;
                exp_q.push_back('{data: d, period: per});
            end else if (++waited > 5000) begin
                n_checks++;
                $display("FAIL push_timeout: byte %0h never accepted", d);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        tx_valid_i = 1'b0;
    endtask

    // Wait for busy_o low at or after cycle 'from'; returns that cycle.
    task automatic wait_busy_low(input int from, output int fall);
        int n;
        n    = 0;
        fall = -1;
        while (fall < 0 && n < 5000) begin
            @(negedge clk_i);
            n++;
            if (cyc >= from && !busy_o) fall = cyc;
        end
        if (fall < 0) begin
            n_checks++;
            $display("FAIL busy_timeout: busy_o still high at cycle %0d", cyc);
        end
        @(posedge clk_i);
        #1;
    endtask

    // Serial-line monitor: compares every cycle of a frame against the expected shape.
    initial begin : monitor
        exp_t       e;
        int         bad;
        int         p;
        int         b;
        logic [7:0] got;
        logic       lvl;
        bit         aborted;
        forever begin
            @(negedge clk_i);
            if (!arst_i && tx_o === 1'b0) begin
                frame_starts.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d with nothing queued", cyc);
                    while (tx_o === 1'b0 && !arst_i) @(negedge clk_i);
                end else begin
                    e       = exp_q.pop_front();
                    p       = e.period;
                    bad     = 0;
                    got     = '0;
                    aborted = 1'b0;
                    for (int k = 0; k < FB * p; k++) begin
                        if (k > 0) @(negedge clk_i);
                        if (arst_i) begin
                            aborted = 1'b1;
                            break;
                        end
                        b = k / p;
                        if (b == 0) lvl = 1'b0;
                        else if (b == FB - 1) lvl = 1'b1;
                        else lvl = e.data[b - 1];
                        if (tx_o !== lvl) bad++;
                        if (b >= 1 && b <= DB && (k % p) == p / 2) got[b - 1] = tx_o;
                    end
                    if (!aborted) begin
                        check("frame_data", 32'(got), 32'(e.data));
                        check("frame_shape_errors", 32'(bad), 32'd0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        int t, t1, t2, rel, fall, n0;

        // Reset values
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_tx", 32'(tx_o), 32'd1);
        check("reset_ready", 32'(tx_ready_o), 32'd1);
        check("reset_busy", 32'(busy_o), 32'd0);

        // Single 0x55, period 4, pushed on the first edge after reset release
        @(posedge clk_i);
        #1;
        arst_i       = 1'b0;
        bit_period_i = 32'd4;
        rel          = cyc;
        push(8'h55, 4, t);
        check("first_accept_edge", 32'(t), 32'(rel + 1));
        @(negedge clk_i);
        @(negedge clk_i);
        check("busy_rise", 32'(busy_o), 32'd1);
        wait_busy_low(t + 2, fall);
        check("start_latency", 32'(last_start()), 32'(t + 2));
        check("busy_fall_55", 32'(fall), 32'(t + 42));
        check("drain_55", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames: no idle gap
        n0 = frame_starts.size();
        push(8'hA3, 4, t1);
        push(8'h0F, 4, t2);
        wait_busy_low(t2 + 2, fall);
        check("b2b_frames", 32'(frame_starts.size() - n0), 32'd2);
        check("b2b_start_gap", 32'(frame_starts[n0 + 1] - frame_starts[n0]), 32'd40);
        check("b2b_busy_fall", 32'(fall), 32'(t1 + 82));

        // Streaming 8 bytes into a 4-deep FIFO
        bit_period_i = 32'd8;
        n0 = frame_starts.size();
        for (int i = 0; i < 8; i++) begin
            push(8'(i), 8, t);
            if (i == 3) check("ready_after_4th", 32'(tx_ready_o), 32'd1);
            if (i == 4) check("ready_after_5th", 32'(tx_ready_o), 32'd0);
        end
        wait_busy_low(t + 2, fall);
        check("stream_frames", 32'(frame_starts.size() - n0), 32'd8);
        check("stream_drain", 32'(exp_q.size()), 32'd0);

        // Period clamping: 0 and 1 both behave as 2
        bit_period_i = 32'd0;
        push(8'hFF, 2, t);
        wait_busy_low(t + 2, fall);
        check("clamp0_busy_fall", 32'(fall), 32'(t + 22));
        bit_period_i = 32'd1;
        push(8'hFF, 2, t);
        wait_busy_low(t + 2, fall);
        check("clamp1_busy_fall", 32'(fall), 32'(t + 22));

        // Period change mid-frame applies only to the next frame
        bit_period_i = 32'd4;
        n0 = frame_starts.size();
        push(8'h3C, 4, t1);
        push(8'hC5, 6, t2);
        repeat (10) @(posedge clk_i);
        #1;
        bit_period_i = 32'd6;
        wait_busy_low(t2 + 2, fall);
        check("chg_start_gap", 32'(frame_starts[n0 + 1] - frame_starts[n0]), 32'd40);
        check("chg_busy_fall", 32'(fall), 32'(t1 + 102));

        // Reset during data bit 3 of 0x00 with two bytes queued
        bit_period_i = 32'd4;
        push(8'h00, 4, t);
        push(8'h11, 4, t1);
        push(8'h22, 4, t2);
        repeat (17) @(posedge clk_i);
        #1;
        check("pre_reset_tx", 32'(tx_o), 32'd0);
        arst_i = 1'b1;
        #1;
        check("abort_tx", 32'(tx_o), 32'd1);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_ready", 32'(tx_ready_o), 32'd1);
        exp_q.delete();
        n0 = frame_starts.size();
        repeat (3) @(posedge clk_i);
        #1;
        arst_i = 1'b0;
        repeat (100) @(posedge clk_i);
        #1;
        check("no_frame_after_reset", 32'(frame_starts.size() - n0), 32'd0);
        check("idle_busy_after_reset", 32'(busy_o), 32'd0);

        // Transmitter recovers normally after the abort
        push(8'h96, 4, t);
        wait_busy_low(t + 2, fall);
        check("recover_start", 32'(last_start()), 32'(t + 2));
        check("recover_busy_fall", 32'(fall), 32'(t + 42));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
